pop_reader: RTL and testbench
=============================

POP_READER -- requirements
Module: pop_reader

Interface
REQ-001 Parameter POP_BITS, default 7500, SHALL set the population vector width in bits.
REQ-002 Parameter GENOME_BITS, default 75, SHALL set the width of one individual in bits.
REQ-003 Parameter NUM_GENOMES, default POP_BITS/GENOME_BITS (100), SHALL set the number of individuals.
REQ-004 Parameter INDEX_W, default 7, SHALL set the index width and satisfy 2^INDEX_W >= NUM_GENOMES.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-007 start  input  1  SHALL request one read pass; sampled only in IDLE.
REQ-008 population  input  POP_BITS  SHALL be the population vector; sampled only on the accepted start edge.
REQ-009 genome_ready  input  1  SHALL indicate the consumer accepts the current genome.
REQ-010 genome_valid  output  1  SHALL indicate genome and genome_index are valid.
REQ-011 genome  output  GENOME_BITS  SHALL carry the current individual.
REQ-012 genome_index  output  INDEX_W  SHALL carry the index of the current individual, 0 to NUM_GENOMES-1.
REQ-013 busy  output  1  SHALL be high in SEND and DONE, low in IDLE.
REQ-014 done  output  1  SHALL pulse high for exactly one cycle after the last genome transfers.

Function
REQ-015 The block SHALL implement three states: IDLE, SEND, DONE.
REQ-016 IDLE: start=1 at a rising edge SHALL copy population into an internal shadow register, clear the index to 0, and enter SEND; start=0 SHALL remain in IDLE.
REQ-017 Latency: genome_valid SHALL be high in the cycle immediately after the edge that accepted start.
REQ-018 SEND: genome_valid SHALL be 1; genome SHALL equal shadow[POP_BITS-1 : POP_BITS-GENOME_BITS], so index 0 is the most-significant slice of population.
REQ-019 Transfer SHALL occur on a rising edge with genome_valid=1 and genome_ready=1; the shadow SHALL shift left by GENOME_BITS with zero fill and the index SHALL increment by 1.
REQ-020 With genome_ready=0, genome, genome_index and genome_valid SHALL hold stable (no retraction, no change).
REQ-021 A transfer at index NUM_GENOMES-1 SHALL move to DONE without incrementing the index past NUM_GENOMES-1 (no wrap to 0).
REQ-022 DONE: done=1 and genome_valid=0 for one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-023 start asserted in SEND or DONE SHALL be ignored and SHALL NOT re-latch population.
REQ-024 Changes on population after the accepted start SHALL NOT affect emitted genomes.
REQ-025 Outputs other than genome SHALL be driven from registered state; genome SHALL be a direct slice of the shadow register.
REQ-026 genome_valid SHALL never be high in IDLE or DONE.

Reset
REQ-027 rst=1 SHALL immediately, without a clock edge, force state IDLE, shadow 0, index 0, genome_valid 0, genome 0, busy 0, done 0.
REQ-028 rst asserted mid-SEND SHALL abort the pass; after release the block SHALL wait in IDLE for a fresh start.
REQ-029 The first start after rst deassertion SHALL be accepted at the first rising edge with rst=0.

Verification
REQ-030 Reset: rst=1 mid-SEND at index 37, no clock edge -> genome_valid=0, busy=0, genome_index=0 in the same cycle.
REQ-031 Full pass, genome_ready held 1, population slices set to their own index value -> 100 transfers on 100 consecutive cycles, genome[i]=i, genome_index=i, done pulse one cycle after index 99, then IDLE.
REQ-032 Backpressure: genome_ready=0 for 5 cycles at index 3 -> genome and genome_index=3 held constant for all 5 cycles, index 4 appears the cycle after ready returns.
REQ-033 Input isolation: population changed to all-ones one cycle after start -> all 100 emitted genomes match the pre-change vector.
REQ-034 Ignored start: start pulsed at index 50 and during DONE -> no re-latch, index continues 51, no second pass, busy falls after DONE.
REQ-035 Bit ordering: population = 1 in bit 7499 only -> genome index 0 = 1 in bit 74, all other genomes 0.

Source files
------------

// File: rtl/pop_reader.sv
`default_nettype none
// ============================================================================
// Module      : pop_reader
// Description : Latches a population vector on start and streams it out one
//               genome per valid/ready handshake, MSB slice first.
// Revision    : 1.0 - initial release
// ============================================================================
module pop_reader #(
    parameter int POP_BITS    = 7500,
    parameter int GENOME_BITS = 75,
    parameter int NUM_GENOMES = POP_BITS / GENOME_BITS,
    parameter int INDEX_W     = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [POP_BITS-1:0]    population,
    input  logic                   genome_ready,
    output logic                   genome_valid,
    output logic [GENOME_BITS-1:0] genome,
    output logic [INDEX_W-1:0]     genome_index,
    output logic                   busy,
    output logic                   done
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SEND = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [INDEX_W-1:0] c_LAST_INDEX = INDEX_W'(NUM_GENOMES - 1);

    logic [1:0]          r_state;
    logic [POP_BITS-1:0] r_shadow;
    logic [INDEX_W-1:0]  r_index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_shadow <= '0;
            r_index  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_shadow <= population;
                        r_index  <= '0;
                        r_state  <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (genome_ready) begin
                        // Next genome always sits in the top slice of the shadow
                        r_shadow <= r_shadow << GENOME_BITS;
                        if (r_index == c_LAST_INDEX) begin
                            r_state <= c_DONE;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign genome_valid = (r_state == c_SEND);
    assign busy         = (r_state != c_IDLE);
    assign done         = (r_state == c_DONE);
    assign genome_index = r_index;
    assign genome       = r_shadow[POP_BITS-1 -: GENOME_BITS];

endmodule
`default_nettype wire

// File: tb/tb_pop_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pop_reader
// Description : Directed self-checking bench for pop_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pop_reader;

    localparam int POP_BITS    = 7500;
    localparam int GENOME_BITS = 75;
    localparam int NUM_GENOMES = 100;
    localparam int INDEX_W     = 7;

    logic                   clk;
    logic                   rst;
    logic                   start;
    logic [POP_BITS-1:0]    population;
    logic                   genome_ready;
    logic                   genome_valid;
    logic [GENOME_BITS-1:0] genome;
    logic [INDEX_W-1:0]     genome_index;
    logic                   busy;
    logic                   done;

    int n_checks = 0;
    int n_fails  = 0;

    logic [POP_BITS-1:0] r_indexed_pop;
    logic [POP_BITS-1:0] r_onehot_pop;
    logic [POP_BITS-1:0] r_ones_pop;

    pop_reader #(
        .POP_BITS    (POP_BITS),
        .GENOME_BITS (GENOME_BITS),
        .NUM_GENOMES (NUM_GENOMES),
        .INDEX_W     (INDEX_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .population   (population),
        .genome_ready (genome_ready),
        .genome_valid (genome_valid),
        .genome       (genome),
        .genome_index (genome_index),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [POP_BITS-1:0] pop);
        population = pop;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Checks genomes from_idx..last with ready held high, then DONE and IDLE.
    task automatic run_pass(input logic [POP_BITS-1:0] exp_pop, input int from_idx);
        genome_ready = 1'b1;
        for (int i = from_idx; i < NUM_GENOMES; i++) begin
            check_eq("valid", 128'(genome_valid), 128'(1));
            check_eq("index", 128'(genome_index), 128'(i));
            check_eq("genome", 128'(genome), 128'(exp_pop[POP_BITS-1-i*GENOME_BITS -: GENOME_BITS]));
            step();
        end
        check_eq("done_pulse", 128'(done), 128'(1));
        check_eq("done_valid", 128'(genome_valid), 128'(0));
        check_eq("done_busy", 128'(busy), 128'(1));
        step();
        check_eq("idle_done", 128'(done), 128'(0));
        check_eq("idle_busy", 128'(busy), 128'(0));
        check_eq("idle_valid", 128'(genome_valid), 128'(0));
    endtask

    task automatic advance_to(input int idx);
        genome_ready = 1'b1;
        for (int i = 0; i < idx; i++) step();
        check_eq("advance_index", 128'(genome_index), 128'(idx));
    endtask

    initial begin
        r_indexed_pop = '0;
        for (int i = 0; i < NUM_GENOMES; i++)
            r_indexed_pop[POP_BITS-1-i*GENOME_BITS -: GENOME_BITS] = GENOME_BITS'(i);
        r_onehot_pop = '0;
        r_onehot_pop[POP_BITS-1] = 1'b1;
        r_ones_pop = '1;

        rst          = 1'b1;
        start        = 1'b0;
        population   = '0;
        genome_ready = 1'b0;
        step();
        step();
        check_eq("rst_valid", 128'(genome_valid), 128'(0));
        check_eq("rst_busy", 128'(busy), 128'(0));
        check_eq("rst_done", 128'(done), 128'(0));
        check_eq("rst_index", 128'(genome_index), 128'(0));
        check_eq("rst_genome", 128'(genome), 128'(0));
        rst = 1'b0;
        step();
        check_eq("idle_no_start", 128'(busy), 128'(0));

        // Full pass, each slice carries its own index
        start_pass(r_indexed_pop);
        run_pass(r_indexed_pop, 0);

        // Backpressure at index 3
        start_pass(r_indexed_pop);
        advance_to(3);
        genome_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_eq("bp_index", 128'(genome_index), 128'(3));
            check_eq("bp_genome", 128'(genome), 128'(3));
            check_eq("bp_valid", 128'(genome_valid), 128'(1));
        end
        genome_ready = 1'b1;
        step();
        check_eq("bp_resume_index", 128'(genome_index), 128'(4));
        run_pass(r_indexed_pop, 4);

        // Population changes one cycle after start
        start_pass(r_indexed_pop);
        population = r_ones_pop;
        run_pass(r_indexed_pop, 0);

        // start during SEND and DONE ignored
        start_pass(r_indexed_pop);
        advance_to(50);
        population = r_ones_pop;
        start      = 1'b1;
        step();
        start      = 1'b0;
        check_eq("ign_index", 128'(genome_index), 128'(51));
        check_eq("ign_genome", 128'(genome), 128'(51));
        for (int i = 51; i < NUM_GENOMES; i++) step();
        check_eq("ign_done", 128'(done), 128'(1));
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("ign_busy_fall", 128'(busy), 128'(0));
        check_eq("ign_done_fall", 128'(done), 128'(0));
        step();
        check_eq("ign_no_pass_valid", 128'(genome_valid), 128'(0));
        check_eq("ign_no_pass_busy", 128'(busy), 128'(0));

        // Bit ordering: only bit POP_BITS-1 set
        start_pass(r_onehot_pop);
        run_pass(r_onehot_pop, 0);

        // Asynchronous reset mid-SEND at index 37
        start_pass(r_indexed_pop);
        advance_to(37);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_valid", 128'(genome_valid), 128'(0));
        check_eq("arst_busy", 128'(busy), 128'(0));
        check_eq("arst_index", 128'(genome_index), 128'(0));
        check_eq("arst_genome", 128'(genome), 128'(0));
        step();
        rst = 1'b0;
        step();
        step();
        check_eq("post_rst_idle_valid", 128'(genome_valid), 128'(0));
        check_eq("post_rst_idle_busy", 128'(busy), 128'(0));

        // First start right after reset release is accepted
        rst = 1'b1;
        step();
        rst = 1'b0;
        start_pass(r_indexed_pop);
        check_eq("rst_release_start", 128'(genome_valid), 128'(1));
        run_pass(r_indexed_pop, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
